// File: rtl/ddr3_req_sched.sv
// Client request scheduler in front of ddr3_controller: serializes single
// reads/writes, owns the tREFI timer and interleaves postponed refreshes.
module ddr3_req_sched #(
    parameter int REFRESH_INTERVAL = 781,
    parameter int MAX_DEBT         = 8,
    parameter int URGENT_DEBT      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [25:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        ctl_rd,
    output logic        ctl_wr,
    output logic        ctl_refresh,
    output logic [25:0] ctl_addr,
    output logic [15:0] ctl_din,
    input  logic        ctl_busy,
    input  logic        ctl_data_ready,
    input  logic [15:0] ctl_dout,
    output logic [3:0]  refresh_debt,
    output logic        refresh_overdue
);
    localparam int TIMER_W = $clog2(REFRESH_INTERVAL);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_t;
    typedef enum logic [1:0] {CMD_RD, CMD_WR, CMD_REF} cmd_t;

    state_t             state, state_nxt;
    cmd_t               cmd, cmd_nxt;
    logic [TIMER_W-1:0] timer;
    logic               tick;
    logic               ref_pick;
    logic               accept;
    logic               ref_issue;
    logic               read_phase;
    logic               data_seen;
    logic               first_data;

    assign tick       = (timer == TIMER_W'(REFRESH_INTERVAL - 1));
    // Refresh wins when debt is urgent, or opportunistically when no client is waiting.
    assign ref_pick   = (state == IDLE) && !ctl_busy &&
                        ((refresh_debt >= 4'(URGENT_DEBT)) ||
                         ((refresh_debt != 4'd0) && !req_valid));
    assign req_ready  = (state == IDLE) && !ctl_busy && !ref_pick && !reset;
    assign accept     = req_valid && req_ready;
    assign ref_issue  = (state == ISSUE) && (cmd == CMD_REF);
    assign read_phase = ((state == SETTLE) || (state == WAIT)) && (cmd == CMD_RD);
    assign first_data = read_phase && ctl_data_ready && !data_seen;

    assign ctl_rd      = (state == ISSUE) && (cmd == CMD_RD);
    assign ctl_wr      = (state == ISSUE) && (cmd == CMD_WR);
    assign ctl_refresh = ref_issue;

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd;
        case (state)
            IDLE: begin
                if (ref_pick) begin
                    state_nxt = ISSUE;
                    cmd_nxt   = CMD_REF;
                end else if (accept) begin
                    state_nxt = ISSUE;
                    cmd_nxt   = req_we ? CMD_WR : CMD_RD;
                end
            end
            ISSUE:  state_nxt = SETTLE;
            SETTLE: state_nxt = WAIT;
            WAIT: begin
                // A read may only retire once its data has been returned.
                if (!ctl_busy && ((cmd != CMD_RD) || data_seen || ctl_data_ready))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cmd             <= CMD_RD;
            timer           <= '0;
            refresh_debt    <= 4'd0;
            refresh_overdue <= 1'b0;
            ctl_addr        <= 26'd0;
            ctl_din         <= 16'd0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= 16'd0;
            data_seen       <= 1'b0;
        end else begin
            state <= state_nxt;
            cmd   <= cmd_nxt;
            timer <= tick ? '0 : timer + TIMER_W'(1);

            // A tick coinciding with a refresh issue cancels out.
            if (ref_issue && !tick)
                refresh_debt <= refresh_debt - 4'd1;
            else if (tick && !ref_issue && (refresh_debt < 4'(MAX_DEBT)))
                refresh_debt <= refresh_debt + 4'd1;
            if (tick && (refresh_debt == 4'(MAX_DEBT)))
                refresh_overdue <= 1'b1;

            if (accept) begin
                ctl_addr <= req_addr;
                ctl_din  <= req_wdata;
            end

            rsp_valid <= first_data;
            if (first_data)
                rsp_rdata <= ctl_dout;

            if (state == ISSUE)
                data_seen <= 1'b0;
            else if (read_phase && ctl_data_ready)
                data_seen <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ddr3_req_sched.sv
// Bench for ddr3_req_sched: directed vector table, multi-cycle corner sequences
// and randomized traffic checked against a transaction-age reference model.
module tb_ddr3_req_sched;
    localparam int RI   = 781;
    localparam int MAXD = 8;
    localparam int URG  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [25:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        ctl_rd, ctl_wr, ctl_refresh;
    logic [25:0] ctl_addr;
    logic [15:0] ctl_din;
    logic        ctl_busy, ctl_data_ready;
    logic [15:0] ctl_dout;
    logic [3:0]  refresh_debt;
    logic        refresh_overdue;

    always #5 clk = ~clk;

    ddr3_req_sched dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ctl_rd(ctl_rd), .ctl_wr(ctl_wr), .ctl_refresh(ctl_refresh),
        .ctl_addr(ctl_addr), .ctl_din(ctl_din),
        .ctl_busy(ctl_busy), .ctl_data_ready(ctl_data_ready), .ctl_dout(ctl_dout),
        .refresh_debt(refresh_debt), .refresh_overdue(refresh_overdue)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a command in flight is tracked by its age in cycles
    // since the controller pulse (age 0 = pulse cycle).
    int          m_timer, m_debt, m_age, m_kind; // kind 0=read 1=write 2=refresh
    bit          m_over, m_inflight, m_got, m_rsp;
    logic [25:0] m_addr;
    logic [15:0] m_din, m_rdata;

    function automatic bit m_wants_refresh();
        return (m_debt >= URG) || (m_debt > 0 && !req_valid);
    endfunction

    task automatic model_check();
        bit pulse;
        pulse = m_inflight && (m_age == 0);
        chk("m_req_ready", req_ready, !reset && !m_inflight && !ctl_busy && !m_wants_refresh());
        chk("m_ctl_rd", ctl_rd, pulse && m_kind == 0);
        chk("m_ctl_wr", ctl_wr, pulse && m_kind == 1);
        chk("m_ctl_refresh", ctl_refresh, pulse && m_kind == 2);
        chk("m_ctl_addr", ctl_addr, m_addr);
        chk("m_ctl_din", ctl_din, m_din);
        chk("m_rsp_valid", rsp_valid, m_rsp);
        chk("m_rsp_rdata", rsp_rdata, m_rdata);
        chk("m_debt", refresh_debt, m_debt);
        chk("m_overdue", refresh_overdue, m_over);
    endtask

    task automatic model_update();
        bit tick_now, ref_now, pick, old_got;
        if (reset) begin
            m_timer = 0; m_debt = 0; m_over = 0; m_inflight = 0; m_age = 0;
            m_kind = 0; m_got = 0; m_rsp = 0; m_rdata = 0; m_addr = 0; m_din = 0;
            return;
        end
        pick     = m_wants_refresh();
        old_got  = m_got;
        tick_now = (m_timer == RI - 1);
        ref_now  = m_inflight && m_age == 0 && m_kind == 2;
        if (tick_now && m_debt == MAXD) m_over = 1;
        if (ref_now && !tick_now) m_debt--;
        else if (tick_now && !ref_now && m_debt < MAXD) m_debt++;
        m_timer = tick_now ? 0 : m_timer + 1;
        m_rsp = 0;
        if (m_inflight && m_kind == 0 && m_age >= 1 && ctl_data_ready && !old_got) begin
            m_rsp   = 1;
            m_rdata = ctl_dout;
        end
        if (m_inflight) begin
            if (m_age >= 1 && m_kind == 0 && ctl_data_ready) m_got = 1;
            if (m_age >= 2 && !ctl_busy && (m_kind != 0 || old_got || ctl_data_ready))
                m_inflight = 0;
            else
                m_age++;
        end else if (!ctl_busy) begin
            if (pick) begin
                m_inflight = 1; m_kind = 2; m_age = 0; m_got = 0;
            end else if (req_valid) begin
                m_inflight = 1; m_kind = req_we ? 1 : 0; m_age = 0; m_got = 0;
                m_addr = req_addr; m_din = req_wdata;
            end
        end
    endtask

    logic        s_ready, s_rd, s_wr, s_refresh, s_rsp, s_over;
    logic [25:0] s_addr;
    logic [15:0] s_din, s_rdata;
    logic [3:0]  s_debt;

    task automatic sample();
        @(negedge clk);
        s_ready = req_ready; s_rd = ctl_rd; s_wr = ctl_wr; s_refresh = ctl_refresh;
        s_addr = ctl_addr; s_din = ctl_din; s_rsp = rsp_valid; s_rdata = rsp_rdata;
        s_debt = refresh_debt; s_over = refresh_overdue;
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        ctl_busy = 0; ctl_data_ready = 0; ctl_dout = 0;
    endtask

    task automatic reset_dut();
        reset = 1;
        idle_inputs();
        tick();
        tick();
        reset = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, s_ready, 0);
        chk({tag, "_rd"}, s_rd, 0);
        chk({tag, "_wr"}, s_wr, 0);
        chk({tag, "_refresh"}, s_refresh, 0);
        chk({tag, "_addr"}, s_addr, 0);
        chk({tag, "_din"}, s_din, 0);
        chk({tag, "_rsp"}, s_rsp, 0);
        chk({tag, "_rdata"}, s_rdata, 0);
        chk({tag, "_debt"}, s_debt, 0);
        chk({tag, "_overdue"}, s_over, 0);
    endtask

    typedef struct {
        bit          vld, we;
        logic [25:0] addr;
        logic [15:0] wdata;
        bit          busy, dr;
        logic [15:0] dout;
        bit          e_ready, e_rd, e_wr, e_rsp;
        logic [15:0] e_rdata;
        logic [25:0] e_addr;
        logic [15:0] e_din;
    } vec_t;

    function automatic vec_t mk(bit vld, bit we, logic [25:0] addr, logic [15:0] wd,
                                bit busy, bit dr, logic [15:0] dout,
                                bit er, bit erd, bit ewr, bit ersp,
                                logic [15:0] erdata, logic [25:0] eaddr, logic [15:0] edin);
        vec_t v;
        v.vld = vld; v.we = we; v.addr = addr; v.wdata = wd; v.busy = busy; v.dr = dr;
        v.dout = dout; v.e_ready = er; v.e_rd = erd; v.e_wr = ewr; v.e_rsp = ersp;
        v.e_rdata = erdata; v.e_addr = eaddr; v.e_din = edin;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        int   n_ref;
        bit   found;
        logic prev_ready;
        int   prev_debt;

        // Write 0x1122 @0 with 3 busy cycles, then read @2 returning 0x5566 plus a spurious data_ready.
        //           vld we addr  wdata    busy dr dout      rdy rd wr rsp rdata    addr din
        tbl.push_back(mk(1, 1, 0, 16'h1122, 0, 0, 0,        1, 0, 0, 0, 0,        0, 0));
        tbl.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0, 1, 0, 0,        0, 16'h1122));
        tbl.push_back(mk(0, 0, 0, 0,        1, 0, 0,        0, 0, 0, 0, 0,        0, 16'h1122));
        tbl.push_back(mk(0, 0, 0, 0,        1, 0, 0,        0, 0, 0, 0, 0,        0, 16'h1122));
        tbl.push_back(mk(0, 0, 0, 0,        1, 0, 0,        0, 0, 0, 0, 0,        0, 16'h1122));
        tbl.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0, 0,        0, 16'h1122));
        tbl.push_back(mk(0, 0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0,        0, 16'h1122));
        tbl.push_back(mk(1, 0, 2, 16'hAAAA, 0, 0, 0,        1, 0, 0, 0, 0,        0, 16'h1122));
        tbl.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 1, 0, 0, 0,        2, 16'hAAAA));
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk(0, 0, 0, 0,    1, 0, 0,        0, 0, 0, 0, 0,        2, 16'hAAAA));
        tbl.push_back(mk(0, 0, 0, 0,        1, 1, 16'h5566, 0, 0, 0, 0, 0,        2, 16'hAAAA));
        tbl.push_back(mk(0, 0, 0, 0,        1, 0, 0,        0, 0, 0, 1, 16'h5566, 2, 16'hAAAA));
        tbl.push_back(mk(0, 0, 0, 0,        1, 1, 16'h7777, 0, 0, 0, 0, 16'h5566, 2, 16'hAAAA));
        tbl.push_back(mk(0, 0, 0, 0,        0, 0, 0,        0, 0, 0, 0, 16'h5566, 2, 16'hAAAA));
        tbl.push_back(mk(0, 0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 16'h5566, 2, 16'hAAAA));

        reset = 1;
        idle_inputs();
        @(posedge clk);
        model_update();
        #1;
        sample();
        chk_all_zero("reset");
        advance();
        reset = 0;

        foreach (tbl[i]) begin
            req_valid = tbl[i].vld; req_we = tbl[i].we; req_addr = tbl[i].addr;
            req_wdata = tbl[i].wdata; ctl_busy = tbl[i].busy;
            ctl_data_ready = tbl[i].dr; ctl_dout = tbl[i].dout;
            sample();
            chk($sformatf("tbl%0d_ready", i), s_ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d_rd", i), s_rd, tbl[i].e_rd);
            chk($sformatf("tbl%0d_wr", i), s_wr, tbl[i].e_wr);
            chk($sformatf("tbl%0d_refresh", i), s_refresh, 0);
            chk($sformatf("tbl%0d_rsp", i), s_rsp, tbl[i].e_rsp);
            chk($sformatf("tbl%0d_rdata", i), s_rdata, tbl[i].e_rdata);
            chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_din", i), s_din, tbl[i].e_din);
            advance();
        end

        // Idle refresh: debt 1 at cycle 781, refresh pulse at 782, debt back to 0.
        reset_dut();
        for (int i = 0; i < RI; i++) begin
            sample();
            if (i == RI - 1) chk("idle_debt_before_tick", s_debt, 0);
            advance();
        end
        sample();
        chk("idle_debt_after_tick", s_debt, 1);
        chk("idle_no_refresh_yet", s_refresh, 0);
        advance();
        sample();
        chk("idle_refresh_pulse", s_refresh, 1);
        advance();
        sample();
        chk("idle_debt_drained", s_debt, 0);
        chk("idle_refresh_single", s_refresh, 0);
        advance();

        // Continuous writes: refresh only pre-empts once debt is urgent.
        reset_dut();
        req_valid = 1; req_we = 1;
        found = 0; prev_ready = 1; prev_debt = 0;
        for (int i = 0; i < 4 * RI + 40 && !found; i++) begin
            req_addr  = 26'($urandom);
            req_wdata = 16'($urandom);
            sample();
            if (s_refresh) begin
                found = 1;
                chk("preempt_ready_low", prev_ready, 0);
                chk("preempt_debt", prev_debt, URG);
            end
            prev_ready = s_ready;
            prev_debt  = s_debt;
            advance();
        end
        chk("preempt_seen", found, 1);

        // Controller stuck busy: debt saturates, overdue sticks, then drain.
        reset_dut();
        ctl_busy = 1;
        for (int i = 0; i < 9 * RI; i++) tick();
        sample();
        chk("sat_debt", s_debt, MAXD);
        chk("sat_overdue", s_over, 1);
        chk("sat_no_refresh", s_refresh, 0);
        advance();
        ctl_busy = 0;
        n_ref = 0;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (s_refresh) n_ref++;
            advance();
        end
        chk("drain_count", n_ref, MAXD);
        sample();
        chk("drain_debt", s_debt, 0);
        chk("drain_overdue_sticky", s_over, 1);
        advance();
        reset = 1;
        tick();
        sample();
        chk("reset_clears_overdue", s_over, 0);
        advance();
        reset = 0;

        // Reset during WAIT of a read; late data_ready must not produce a response.
        reset_dut();
        req_valid = 1; req_we = 0; req_addr = 26'h155; req_wdata = 16'h0F0F;
        tick();
        req_valid = 0;
        tick();
        ctl_busy = 1;
        tick();
        tick();
        reset = 1;
        tick();
        ctl_data_ready = 1; ctl_dout = 16'hBEEF;
        sample();
        chk_all_zero("rst_wait");
        advance();
        reset = 0; ctl_busy = 0;
        sample();
        chk("late_dr_rsp0", s_rsp, 0);
        advance();
        ctl_data_ready = 0;
        sample();
        chk("late_dr_rsp1", s_rsp, 0);
        chk("late_dr_rdata", s_rdata, 0);
        advance();

        // Randomized traffic against the reference model.
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 399) == 0);
            req_valid      = ($urandom_range(0, 2) != 0);
            req_we         = 1'($urandom);
            req_addr       = 26'($urandom);
            req_wdata      = 16'($urandom);
            ctl_busy       = ($urandom_range(0, 3) == 0);
            ctl_data_ready = ($urandom_range(0, 5) == 0);
            ctl_dout       = 16'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
